// File: rtl/reg_file.sv
// Integer register file: two combinational read ports with optional write bypass,
// one synchronous write port, one committed-state debug port, x0 hardwired to zero.
module reg_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [15:0]     wr_count
);

    localparam int          AW    = $clog2(NREGS);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [XLEN-1:0] regs [DEPTH];
    logic            wr_ok;

    // Address is architecturally live only when nonzero and inside the implemented range.
    function automatic logic in_range(input logic [4:0] a);
        return (a != 5'd0) && (32'(a) < NREGS);
    endfunction

    assign wr_ok = we && in_range(rd_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (wr_ok) begin
            regs[rd_addr[AW-1:0]] <= rd_data;
            if (wr_count != '1) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // rst_n gating keeps a pending write from bypassing onto the ports while in reset.
    always_comb begin
        rs1_data = '0;
        if (rst_n && in_range(rs1_addr)) begin
            if (BYPASS && wr_ok && (rd_addr == rs1_addr)) begin
                rs1_data = rd_data;
            end else begin
                rs1_data = regs[rs1_addr[AW-1:0]];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rst_n && in_range(rs2_addr)) begin
            if (BYPASS && wr_ok && (rd_addr == rs2_addr)) begin
                rs2_data = rd_data;
            end else begin
                rs2_data = regs[rs2_addr[AW-1:0]];
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        if (rst_n && in_range(dbg_addr)) begin
            dbg_data = regs[dbg_addr[AW-1:0]];
        end
    end

endmodule
